// File: rtl/wb_master_arbiter.sv
// Four-port round-robin arbiter and sequencer in front of a single Wishbone master.
// Latches the winning command, pulses start, retries on rty and reports completion per owner.
module wb_master_arbiter #(
  parameter int aw        = 32,
  parameter int dw        = 32,
  parameter int MAX_RETRY = 3
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  input  logic [3:0]      req_i,
  input  logic [4*aw-1:0] req_adr_i,
  input  logic [4*dw-1:0] req_dat_i,
  input  logic [15:0]     req_sel_i,
  input  logic [3:0]      req_we_i,
  output logic [3:0]      gnt_o,
  output logic [3:0]      done_o,
  output logic [3:0]      err_o,
  output logic [dw-1:0]   rd_dat_o,
  output logic            busy_o,
  output logic            m_start,
  output logic [aw-1:0]   m_address,
  output logic [3:0]      m_selection,
  output logic            m_write,
  output logic [dw-1:0]   m_data_wr,
  input  logic [dw-1:0]   m_data_rd,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BACKOFF} state_t;

  state_t          state, state_nxt;
  logic [1:0]      ptr, ptr_nxt;
  logic [RW-1:0]   retry_cnt, retry_nxt;
  logic            cause_rty, cause_nxt;

  logic [3:0]      gnt_nxt, done_nxt, err_nxt;
  logic [dw-1:0]   rd_dat_nxt, m_data_wr_nxt;
  logic [aw-1:0]   m_address_nxt;
  logic [3:0]      m_selection_nxt;
  logic            m_write_nxt;

  // Round-robin pick: first requester above the last owner, wrapping modulo 4.
  logic [1:0]      win, idx;
  logic            found;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req_i[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_nxt       = state;
    ptr_nxt         = ptr;
    retry_nxt       = retry_cnt;
    cause_nxt       = cause_rty;
    gnt_nxt         = gnt_o;
    done_nxt        = '0;
    err_nxt         = '0;
    rd_dat_nxt      = rd_dat_o;
    m_address_nxt   = m_address;
    m_selection_nxt = m_selection;
    m_write_nxt     = m_write;
    m_data_wr_nxt   = m_data_wr;

    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt       = ISSUE;
          m_address_nxt   = req_adr_i[win*aw +: aw];
          m_data_wr_nxt   = req_dat_i[win*dw +: dw];
          m_selection_nxt = req_sel_i[win*4 +: 4];
          m_write_nxt     = req_we_i[win];
          gnt_nxt         = 4'(4'b0001 << win);
          ptr_nxt         = win;
          retry_nxt       = '0;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (wb_err_i) begin
          state_nxt = BACKOFF;
          cause_nxt = 1'b0;
        end else if (wb_rty_i) begin
          state_nxt = BACKOFF;
          cause_nxt = 1'b1;
        end else if (wb_ack_i) begin
          state_nxt = IDLE;
          done_nxt  = gnt_o;
          gnt_nxt   = '0;
          if (!m_write) rd_dat_nxt = m_data_rd;
        end
      end
      BACKOFF: begin
        if (cause_rty && (retry_cnt < RW'(MAX_RETRY))) begin
          state_nxt = ISSUE;
          retry_nxt = retry_cnt + RW'(1);
        end else begin
          state_nxt = IDLE;
          done_nxt  = gnt_o;
          err_nxt   = gnt_o;
          gnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Outputs are registered from next-state values so busy_o and m_start line up with the state.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      ptr         <= 2'd3;
      retry_cnt   <= '0;
      cause_rty   <= 1'b0;
      gnt_o       <= '0;
      done_o      <= '0;
      err_o       <= '0;
      rd_dat_o    <= '0;
      busy_o      <= 1'b0;
      m_start     <= 1'b0;
      m_address   <= '0;
      m_selection <= '0;
      m_write     <= 1'b0;
      m_data_wr   <= '0;
    end else begin
      ptr         <= ptr_nxt;
      retry_cnt   <= retry_nxt;
      cause_rty   <= cause_nxt;
      gnt_o       <= gnt_nxt;
      done_o      <= done_nxt;
      err_o       <= err_nxt;
      rd_dat_o    <= rd_dat_nxt;
      busy_o      <= (state_nxt != IDLE);
      m_start     <= (state_nxt == ISSUE);
      m_address   <= m_address_nxt;
      m_selection <= m_selection_nxt;
      m_write     <= m_write_nxt;
      m_data_wr   <= m_data_wr_nxt;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration, retries and completion timing.
module tb_wb_master_arbiter;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MAX_RETRY = 3;

  logic            wb_clk;
  logic            wb_rst_n;
  logic [3:0]      req_i;
  logic [4*AW-1:0] req_adr_i;
  logic [4*DW-1:0] req_dat_i;
  logic [15:0]     req_sel_i;
  logic [3:0]      req_we_i;
  logic [3:0]      gnt_o, done_o, err_o;
  logic [DW-1:0]   rd_dat_o;
  logic            busy_o, m_start;
  logic [AW-1:0]   m_address;
  logic [3:0]      m_selection;
  logic            m_write;
  logic [DW-1:0]   m_data_wr;
  logic [DW-1:0]   m_data_rd;
  logic            wb_ack_i, wb_err_i, wb_rty_i;

  wb_master_arbiter #(.aw(AW), .dw(DW), .MAX_RETRY(MAX_RETRY)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .req_i(req_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .req_sel_i(req_sel_i), .req_we_i(req_we_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rd_dat_o(rd_dat_o), .busy_o(busy_o),
    .m_start(m_start), .m_address(m_address), .m_selection(m_selection),
    .m_write(m_write), .m_data_wr(m_data_wr), .m_data_rd(m_data_rd),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state: last owner and the read-data register contents.
  int          ptr = 3;
  logic [31:0] rd_hold = '0;

  logic [31:0] adr_a [4];
  logic [31:0] dat_a [4];
  logic [3:0]  sel_a [4];
  logic        we_a  [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge wb_clk);
    cyc++;
  endtask

  task automatic drive_slots();
    for (int i = 0; i < 4; i++) begin
      req_adr_i[i*AW +: AW] = adr_a[i];
      req_dat_i[i*DW +: DW] = dat_a[i];
      req_sel_i[i*4 +: 4]   = sel_a[i];
      req_we_i[i]           = we_a[i];
    end
  endtask

  task automatic random_slots();
    for (int i = 0; i < 4; i++) begin
      adr_a[i] = $urandom;
      dat_a[i] = $urandom;
      sel_a[i] = 4'($urandom);
      we_a[i]  = 1'($urandom);
    end
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_gnt"},   gnt_o,   4'b0);
    check({tag, "_busy"},  busy_o,  1'b0);
    check({tag, "_done"},  done_o,  4'b0);
    check({tag, "_err"},   err_o,   4'b0);
    check({tag, "_start"}, m_start, 1'b0);
  endtask

  // One transaction from request to completion. The slave answers nrty retries, then
  // ack or err; wait_cyc < 0 picks a random 0..3 cycle response delay per attempt.
  task automatic run_txn(input logic [3:0] reqs, input logic [3:0] reqs_after,
                         input int nrty, input bit fin_err, input int wait_cyc,
                         input logic [31:0] rd_val, input bit noise,
                         output int first_start);
    int win, used, resp_idx, starts, w;
    logic [3:0] oh;
    bit is_rty, fin;
    logic [31:0] exp_rd;
    win = -1;
    for (int i = 1; i <= 4; i++)
      if (win < 0 && reqs[(ptr + i) % 4]) win = (ptr + i) % 4;
    oh = 4'(1 << win);
    req_i = reqs;
    drive_slots();
    tick();
    ptr = win;
    first_start = cyc;
    check("grant",     gnt_o,       oh);
    check("m_address", m_address,   adr_a[win]);
    check("m_sel",     m_selection, sel_a[win]);
    check("m_write",   m_write,     we_a[win]);
    check("busy_grant", busy_o,     1'b1);
    starts = 0; used = 0; resp_idx = 0; fin = 0;
    while (!fin) begin
      check("m_start", m_start, 1'b1);
      starts++;
      check("gnt_hold",  gnt_o,     oh);
      check("dat_hold",  m_data_wr, dat_a[win]);
      if (noise) begin
        req_i    = 4'($urandom);
        wb_ack_i = 1'($urandom);
        wb_err_i = 1'($urandom);
      end
      tick();
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      w = (wait_cyc < 0) ? $urandom_range(0, 3) : wait_cyc;
      repeat (w) begin
        check("wait_start", m_start, 1'b0);
        check("wait_done",  done_o,  4'b0);
        check("wait_busy",  busy_o,  1'b1);
        tick();
      end
      check("resp_start", m_start, 1'b0);
      is_rty = (resp_idx < nrty);
      m_data_rd = $urandom;
      if (is_rty) begin
        wb_rty_i = 1'b1;
        if (noise) wb_ack_i = 1'($urandom);
      end else if (fin_err) begin
        wb_err_i = 1'b1;
        if (noise) begin wb_rty_i = 1'($urandom); wb_ack_i = 1'($urandom); end
      end else begin
        wb_ack_i  = 1'b1;
        m_data_rd = rd_val;
      end
      resp_idx++;
      tick();
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      m_data_rd = $urandom;
      if (!is_rty && !fin_err) begin
        exp_rd = we_a[win] ? rd_hold : rd_val;
        check("ack_done", done_o,   oh);
        check("ack_err",  err_o,    4'b0);
        check("ack_gnt",  gnt_o,    4'b0);
        check("ack_busy", busy_o,   1'b0);
        check("rd_dat",   rd_dat_o, exp_rd);
        rd_hold = exp_rd;
        req_i = reqs_after;
        fin = 1;
      end else begin
        check("bo_busy",  busy_o,  1'b1);
        check("bo_done",  done_o,  4'b0);
        check("bo_start", m_start, 1'b0);
        if (noise) wb_ack_i = 1'($urandom);
        if (is_rty && used < MAX_RETRY) begin
          used++;
          tick();
          wb_ack_i = 1'b0;
        end else begin
          tick();
          wb_ack_i = 1'b0;
          check("fail_done", done_o,   oh);
          check("fail_err",  err_o,    oh);
          check("fail_gnt",  gnt_o,    4'b0);
          check("fail_busy", busy_o,   1'b0);
          check("fail_rd",   rd_dat_o, rd_hold);
          req_i = reqs_after;
          fin = 1;
        end
      end
    end
    check("n_start", starts, (nrty <= MAX_RETRY) ? nrty + 1 : MAX_RETRY + 1);
  endtask

  int s0, s1;

  initial begin
    wb_rst_n = 1'b0;
    req_i = 4'hF;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    m_data_rd = '0;
    random_slots();
    drive_slots();

    // Reset held with all requests pending.
    repeat (3) begin
      tick();
      idle_checks("reset");
      check("reset_rd",   rd_dat_o,    '0);
      check("reset_adr",  m_address,   '0);
      check("reset_wdat", m_data_wr,   '0);
      check("reset_sel",  m_selection, '0);
      check("reset_we",   m_write,     1'b0);
    end
    wb_rst_n = 1'b1;

    // Round-robin with zero-wait acks; each requester drops on its done.
    run_txn(4'hF, 4'hE, 0, 0, 0, 32'h1111_0000, 0, s0);
    run_txn(4'hE, 4'hC, 0, 0, 0, 32'h1111_0001, 0, s1);
    check("rr_space1", s1 - s0, 3);
    run_txn(4'hC, 4'h8, 0, 0, 0, 32'h1111_0002, 0, s0);
    check("rr_space2", s0 - s1, 3);
    run_txn(4'h8, 4'h3, 0, 0, 0, 32'h1111_0003, 0, s1);
    check("rr_space3", s1 - s0, 3);
    run_txn(4'h3, 4'h0, 0, 0, 0, 32'h1111_0004, 0, s0);
    check("rr_space4", s0 - s1, 3);
    check("rr_wrap_owner", ptr, 0);
    tick();
    idle_checks("rr_idle");

    // Directed read: requester 2, ack in the second WAIT cycle.
    adr_a[2] = 32'h0000_0010; we_a[2] = 1'b0;
    run_txn(4'b0100, 4'b0, 0, 0, 1, 32'hDEAD_BEEF, 0, s0);
    tick();
    idle_checks("read_idle");

    // Retry success: requester 1 write, rty, rty, ack.
    dat_a[1] = 32'h1234_5678; we_a[1] = 1'b1;
    run_txn(4'b0010, 4'b0, 2, 0, -1, 32'h0BAD_0BAD, 0, s0);
    check("retry_rd_kept", rd_dat_o, 32'hDEAD_BEEF);
    tick();

    // Retry exhaustion, then a plain bus error.
    run_txn(4'b1000, 4'b0, 6, 0, -1, 32'h0, 0, s0);
    tick();
    run_txn(4'b0001, 4'b0, 0, 1, 0, 32'h0, 0, s0);
    tick();

    // Mid-transaction reset.
    req_i = 4'b0100;
    tick();
    req_i = 4'b0;
    tick();
    wb_rst_n = 1'b0;
    tick();
    idle_checks("midrst");
    check("midrst_rd", rd_dat_o, '0);
    tick();
    idle_checks("midrst2");
    wb_rst_n = 1'b1;
    ptr = 3;
    rd_hold = '0;
    run_txn(4'hF, 4'b0, 0, 0, -1, 32'hCAFE_F00D, 0, s0);
    check("midrst_first_owner", ptr, 0);
    tick();

    // Randomized transactions with bus noise outside WAIT and competing responses.
    for (int t = 0; t < 60; t++) begin
      random_slots();
      run_txn(4'($urandom_range(1, 15)), 4'b0, $urandom_range(0, 5),
              ($urandom_range(0, 3) == 0), -1, $urandom, 1, s0);
      tick();
      idle_checks("rand_idle");
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("rand_idle_busy", busy_o, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Four-port round-robin arbiter and sequencer placed in front of `wb_master_interface`. It shares one Wishbone master among four requesters. For each transaction it latches the winning request, issues a single-cycle `start` to the master and tracks completion via the bus `ack`/`err`/`rty` lines. It retries transactions the slave reports as `rty` and returns read data plus a completion/error pulse to the owning requester.

## Interface
- `aw`, 32: address width.
- `dw`, 32: data width.
- `MAX_RETRY`, 3: re-issues allowed after `rty` (0 = none). Counter width is `$clog2(MAX_RETRY+1)` with a minimum of 1.

Ports:
- `wb_clk`  in  1  clock; all logic on rising edge.
- `wb_rst_n`  in  1  synchronous, active-low reset.
- `req_i`  in  4  per-requester request level.
- `req_adr_i`  in  4*aw  address; slot i at `[i*aw +: aw]`.
- `req_dat_i`  in  4*dw  write data; slot i at `[i*dw +: dw]`.
- `req_sel_i`  in  16  byte selects; slot i at `[i*4 +: 4]`.
- `req_we_i`  in  4  1 = write.
- `gnt_o`  out  4  one-hot owner; held from grant through final completion.
- `done_o`  out  4  one-cycle completion pulse to the owner.
- `err_o`  out  4  one-cycle error pulse; coincident with `done_o`.
- `rd_dat_o`  out  dw  read data; valid while `done_o` is high, held until next completion.
- `busy_o`  out  1  high whenever state is not IDLE.
- `m_start`  out  1  start pulse to the master.
- `m_address`  out  aw  latched address to the master.
- `m_selection`  out  4  latched selects to the master.
- `m_write`  out  1  latched write flag to the master.
- `m_data_wr`  out  dw  latched write data to the master.
- `m_data_rd`  in  dw  master read data; valid in the `wb_ack_i` cycle.
- `wb_ack_i`  in  1  bus acknowledge, monitored directly.
- `wb_err_i`  in  1  bus error, monitored directly.
- `wb_rty_i`  in  1  bus retry, monitored directly.

## Operation
- All outputs are registered. After any cycle with `wb_rst_n`=0, every output is 0, state is IDLE, retry count is 0 and the round-robin pointer is 3, so requester 0 has first priority.
- States: IDLE, ISSUE, WAIT, BACKOFF.
- **IDLE.** If any `req_i` bit is set, the winner is the first set bit scanning upward from pointer+1, modulo 4. Next state is ISSUE. On that transition:
  - latch the winner's `adr`/`dat`/`sel`/`we` into the `m_*` outputs;
  - set `gnt_o` one-hot;
  - update the pointer to the winner;
  - clear the retry count.
- **ISSUE.** `m_start`=1 for exactly this cycle. Next state is WAIT unconditionally.
- **WAIT.** Priority order is `wb_err_i`, then `wb_rty_i`, then `wb_ack_i`.
  - `err` or `rty` goes to BACKOFF and records the cause.
  - `ack` goes to IDLE. On that transition, `done_o[owner]`=1 and `gnt_o` clears. If `m_write`=0, `rd_dat_o` captures `m_data_rd`; a write leaves `rd_dat_o` unchanged.
  - If none of the three is set, remain in WAIT.
- **BACKOFF.** Lasts one cycle and covers the master's ERROR state.
  - Cause `rty` with retry count < `MAX_RETRY`: increment the count and go to ISSUE with the same latched command and the same grant.
  - Otherwise go to IDLE with `done_o[owner]`=1, `err_o[owner]`=1 and `gnt_o` cleared.
- A request deasserted before it is granted is dropped. Once granted, the transaction runs to completion regardless of `req_i`. Requesters must drop `req_i` in the `done_o` cycle, or they will be re-arbitrated.
- `m_address`, `m_selection`, `m_write` and `m_data_wr` hold their value from the grant until the next grant.
- Bus responses seen outside WAIT are ignored.

## Timing
- Request seen at edge 0 → `gnt_o` and `m_*` valid from cycle 1 → `m_start` in cycle 1 → master in WAIT_ACK from cycle 2.
- Earliest `ack` is in cycle 2.
- `ack` in cycle k → `done_o` and `rd_dat_o` in cycle k+1 → earliest next `m_start` in cycle k+2.
- `err` or `rty` in cycle k → BACKOFF in cycle k+1.
  - If retrying, `m_start` re-asserts in cycle k+2.
  - If not retrying, `done_o`/`err_o` pulse in cycle k+2.
- Back-to-back zero-wait transactions take 3 cycles each.
- Reset asserted mid-transaction aborts immediately: no `done_o` pulse. The master's active-high reset is driven from the same source (`~wb_rst_n`) at top level.

## Test plan
- **Reset.** Hold `wb_rst_n`=0 with `req_i`=4'hF for 3 cycles → all outputs 0. After release, `gnt_o`=4'b0001 one cycle later.
- **Read.** Requester 2 reads 0x0000_0010; slave acks in the 2nd WAIT cycle with 0xDEAD_BEEF → single `m_start`; `done_o`=4'b0100 with `rd_dat_o`=0xDEAD_BEEF; `err_o`=0; `busy_o` low the same cycle.
- **Round-robin.** `req_i`=4'hF held, each request dropped on its `done_o`, all acks immediate → grant order 0, 1, 2, 3. Re-raising `req_i`=4'b0011 after requester 3 completes → requester 0 is granted next. Every `m_start` is 3 cycles apart.
- **Retry success.** Requester 1 writes 0x1234_5678; slave answers `rty`, `rty`, then `ack` → exactly 3 `m_start` pulses; `m_data_wr` stays 0x1234_5678 throughout; `done_o`=4'b0010 with `err_o`=0; `rd_dat_o` unchanged.
- **Retry exhaustion and error.** `MAX_RETRY`=3, slave always `rty` → 4 `m_start` pulses, then `done_o` and `err_o` pulse together for the owner. A separate `wb_err_i` on the first attempt → no re-issue; `err_o` pulses 2 cycles after the `err`.
- **Mid-transaction reset.** `wb_rst_n` driven low during WAIT → next cycle `gnt_o`=0, `busy_o`=0, no `done_o`. The first request after reset goes to requester 0.
